// File: rtl/gn_collector_if.sv
// Collector bundle: nonce inputs and flush/pop from the core side, queue head and status toward the host.
// The slave modport belongs to gn_collector; dbg_* exposes arbiter state for observation.
interface gn_collector_if #(
  parameter int NCORES = 2,
  parameter int DEPTH  = 4,
  parameter int CIDX_W = 1
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   flush;
  logic [NCORES-1:0]      gn_match;
  logic [32*NCORES-1:0]   golden_nonce;
  logic                   pop;
  logic                   nonce_valid;
  logic [31:0]            nonce_out;
  logic [CIDX_W-1:0]      core_out;
  logic [CNT_W-1:0]       count;
  logic                   overflow;
  logic [NCORES-1:0]      dbg_pending;
  logic [CIDX_W-1:0]      dbg_rr_ptr;

  // Handshake: the head entry is valid while nonce_valid=1; it is consumed on the rising edge where pop=1.
  // A pop while nonce_valid=0 is ignored.
  modport master (
    output flush, gn_match, golden_nonce, pop,
    input  nonce_valid, nonce_out, core_out, count, overflow, dbg_pending, dbg_rr_ptr
  );

  modport slave (
    input  flush, gn_match, golden_nonce, pop,
    output nonce_valid, nonce_out, core_out, count, overflow, dbg_pending, dbg_rr_ptr
  );
endinterface

// File: rtl/gn_collector.sv
// Catches per-core golden-nonce pulses in holding slots and moves them through a round-robin
// arbiter into a shared show-ahead FIFO.
module gn_collector #(
  parameter int NCORES = 2,
  parameter int DEPTH  = 4,
  parameter int CIDX_W = 1
) (
  input  logic          hash_clk,
  input  logic          reset_n,
  gn_collector_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NCORES-1:0]      pending_q, pending_d;
  logic [31:0]            hold_q [NCORES];
  logic [31:0]            hold_d [NCORES];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_set;
  logic [CIDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CIDX_W+31:0]     mem_q [DEPTH];

  logic                   grant;
  logic [CIDX_W-1:0]      win;
  logic                   rd_en;
  int                     best_dist;
  int                     cur_dist;

  // Winner is the pending core with the smallest forward distance from rr_ptr.
  always_comb begin
    grant     = 1'b0;
    win       = '0;
    best_dist = NCORES;
    cur_dist  = 0;
    if (count_q < CNT_W'(DEPTH)) begin
      for (int i = 0; i < NCORES; i++) begin
        if (pending_q[i]) begin
          cur_dist = (i + NCORES - int'(rr_ptr_q)) % NCORES;
          if (cur_dist < best_dist) begin
            best_dist = cur_dist;
            win       = CIDX_W'(i);
            grant     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (int'(win) + 1 == NCORES) ? '0 : win + CIDX_W'(1);
    end
  end

  // A slot being granted this cycle is free again, so a new pulse reloads it without loss.
  always_comb begin
    overflow_set = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      pending_d[i] = pending_q[i];
      hold_d[i]    = hold_q[i];
      if (grant && (win == CIDX_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (bus.gn_match[i]) begin
        if (!pending_d[i]) begin
          hold_d[i]    = bus.golden_nonce[32*i +: 32];
          pending_d[i] = 1'b1;
        end else begin
          overflow_set = 1'b1;
        end
      end
    end
  end

  assign rd_en = bus.pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (grant && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!grant && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rr_ptr_q   <= '0;
      for (int i = 0; i < NCORES; i++) begin
        hold_q[i] <= '0;
      end
    end else if (bus.flush) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_q | overflow_set;
      for (int i = 0; i < NCORES; i++) begin
        hold_q[i] <= hold_d[i];
      end
      if (grant) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge hash_clk) begin
    if (grant && !bus.flush) begin
      mem_q[wr_ptr_q] <= {win, hold_q[win]};
    end
  end

  assign bus.nonce_valid = (count_q != '0);
  assign bus.nonce_out   = bus.nonce_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign bus.core_out    = bus.nonce_valid ? mem_q[rd_ptr_q][CIDX_W+31:32] : '0;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.dbg_pending = pending_q;
  assign bus.dbg_rr_ptr  = rr_ptr_q;
endmodule

// File: tb/tb_gn_collector.sv
// Directed bench for gn_collector with NCORES=2, DEPTH=4: hand-computed expectations,
// head entries compared against an expected queue of {core, nonce}.
module tb_gn_collector;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [32:0] exp_q[$];

  gn_collector_if #(.NCORES(2), .DEPTH(4), .CIDX_W(1)) bus ();

  gn_collector #(.NCORES(2), .DEPTH(4), .CIDX_W(1)) dut (
    .hash_clk (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic match(input logic [1:0] m, input logic [31:0] n0, input logic [31:0] n1);
    bus.gn_match     = m;
    bus.golden_nonce = {n1, n0};
    cycle();
    bus.gn_match     = 2'b00;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
    check_eq({tag, "_valid"}, 64'(bus.nonce_valid), 64'd1);
    check_eq({tag, "_head"}, 64'({bus.core_out, bus.nonce_out}), 64'(e));
    bus.pop = 1'b1;
    cycle();
    bus.pop = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    bus.flush        = 1'b0;
    bus.gn_match     = 2'b00;
    bus.golden_nonce = '0;
    bus.pop          = 1'b0;
    #12;
    check_eq("rst_valid", 64'(bus.nonce_valid), 64'd0);
    check_eq("rst_nonce", 64'(bus.nonce_out), 64'd0);
    check_eq("rst_core", 64'(bus.core_out), 64'd0);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // single match, two-edge latency
    match(2'b01, 32'h12345678, 32'h0);
    check_eq("t1_pend", 64'(bus.dbg_pending), 64'd1);
    check_eq("t1_early_valid", 64'(bus.nonce_valid), 64'd0);
    cycle();
    check_eq("t1_valid", 64'(bus.nonce_valid), 64'd1);
    check_eq("t1_nonce", 64'(bus.nonce_out), 64'h12345678);
    check_eq("t1_core", 64'(bus.core_out), 64'd0);
    check_eq("t1_count", 64'(bus.count), 64'd1);
    bus.pop = 1'b1;
    cycle();
    bus.pop = 1'b0;
    check_eq("t1_count_pop", 64'(bus.count), 64'd0);
    check_eq("t1_valid_pop", 64'(bus.nonce_valid), 64'd0);

    // round robin
    do_flush();
    check_eq("t2_rr_flush", 64'(bus.dbg_rr_ptr), 64'd0);
    match(2'b11, 32'hA0A0A0A0, 32'hA1A1A1A1);
    cycle();
    cycle();
    check_eq("t2_rr_a", 64'(bus.dbg_rr_ptr), 64'd0);
    check_eq("t2_count_a", 64'(bus.count), 64'd2);
    exp_q.push_back({1'b0, 32'hA0A0A0A0});
    exp_q.push_back({1'b1, 32'hA1A1A1A1});
    pop_check("t2_a0");
    pop_check("t2_a1");
    match(2'b11, 32'hB0B0B0B0, 32'hB1B1B1B1);
    cycle();
    cycle();
    exp_q.push_back({1'b0, 32'hB0B0B0B0});
    exp_q.push_back({1'b1, 32'hB1B1B1B1});
    pop_check("t2_b0");
    pop_check("t2_b1");
    match(2'b10, 32'h0, 32'hC1C1C1C1);
    cycle();
    check_eq("t2_rr_wrap", 64'(bus.dbg_rr_ptr), 64'd0);
    match(2'b11, 32'hD0D0D0D0, 32'hD1D1D1D1);
    cycle();
    cycle();
    check_eq("t2_count_d", 64'(bus.count), 64'd3);
    exp_q.push_back({1'b1, 32'hC1C1C1C1});
    exp_q.push_back({1'b0, 32'hD0D0D0D0});
    exp_q.push_back({1'b1, 32'hD1D1D1D1});
    pop_check("t2_c1");
    pop_check("t2_d0");
    pop_check("t2_d1");

    // full queue, overflow, full+pop+pending
    do_flush();
    match(2'b01, 32'h00000010, 32'h0);
    match(2'b10, 32'h0, 32'h00000011);
    match(2'b01, 32'h00000012, 32'h0);
    match(2'b10, 32'h0, 32'h00000013);
    match(2'b01, 32'h00000014, 32'h0);
    match(2'b10, 32'h0, 32'h00000015);
    check_eq("t3_count_full", 64'(bus.count), 64'd4);
    check_eq("t3_pend_both", 64'(bus.dbg_pending), 64'd3);
    check_eq("t3_ovf_clear", 64'(bus.overflow), 64'd0);
    exp_q.push_back({1'b0, 32'h00000010});
    exp_q.push_back({1'b1, 32'h00000011});
    exp_q.push_back({1'b0, 32'h00000012});
    exp_q.push_back({1'b1, 32'h00000013});
    match(2'b01, 32'h00000016, 32'h0);
    check_eq("t3_ovf_set", 64'(bus.overflow), 64'd1);
    check_eq("t3_pend_kept", 64'(bus.dbg_pending), 64'd3);
    pop_check("t3_p0");
    check_eq("t4_count_nowr", 64'(bus.count), 64'd3);
    check_eq("t4_pend_nowr", 64'(bus.dbg_pending), 64'd3);
    cycle();
    check_eq("t3_count_refill", 64'(bus.count), 64'd4);
    check_eq("t3_pend_refill", 64'(bus.dbg_pending), 64'd2);
    exp_q.push_back({1'b0, 32'h00000014});
    pop_check("t4_p1");
    check_eq("t4_count_3", 64'(bus.count), 64'd3);
    cycle();
    check_eq("t4_count_4", 64'(bus.count), 64'd4);
    check_eq("t4_pend_none", 64'(bus.dbg_pending), 64'd0);
    exp_q.push_back({1'b1, 32'h00000015});
    for (int i = 0; i < 4; i++) pop_check("t3_drain");
    check_eq("t3_count_empty", 64'(bus.count), 64'd0);
    check_eq("t3_ovf_sticky", 64'(bus.overflow), 64'd1);
    do_flush();
    check_eq("t3_ovf_flush", 64'(bus.overflow), 64'd0);

    // pop on empty
    bus.pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("t5_count", 64'(bus.count), 64'd0);
      check_eq("t5_valid", 64'(bus.nonce_valid), 64'd0);
    end
    bus.pop = 1'b0;
    match(2'b10, 32'h0, 32'hCAFEF00D);
    cycle();
    check_eq("t5_count_1", 64'(bus.count), 64'd1);
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    pop_check("t5_after");
    check_eq("t5_count_0", 64'(bus.count), 64'd0);

    // flush with queued + pending + simultaneous match/pop
    match(2'b01, 32'h00000020, 32'h0);
    match(2'b10, 32'h0, 32'h00000021);
    match(2'b01, 32'h00000022, 32'h0);
    match(2'b10, 32'h0, 32'h00000023);
    check_eq("t6_count_3", 64'(bus.count), 64'd3);
    check_eq("t6_pend", 64'(bus.dbg_pending), 64'd2);
    bus.flush        = 1'b1;
    bus.pop          = 1'b1;
    bus.gn_match     = 2'b11;
    bus.golden_nonce = {32'h00000025, 32'h00000024};
    cycle();
    bus.flush    = 1'b0;
    bus.pop      = 1'b0;
    bus.gn_match = 2'b00;
    check_eq("t6_count_0", 64'(bus.count), 64'd0);
    check_eq("t6_valid_0", 64'(bus.nonce_valid), 64'd0);
    check_eq("t6_ovf_0", 64'(bus.overflow), 64'd0);
    check_eq("t6_pend_0", 64'(bus.dbg_pending), 64'd0);
    check_eq("t6_rr_0", 64'(bus.dbg_rr_ptr), 64'd0);
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t6_later_valid", 64'(bus.nonce_valid), 64'd0);
    check_eq("t6_later_count", 64'(bus.count), 64'd0);

    // asynchronous reset mid-burst
    match(2'b01, 32'h0BADBEEF, 32'h0);
    cycle();
    check_eq("t6_pre_rst_valid", 64'(bus.nonce_valid), 64'd1);
    bus.gn_match = 2'b11;
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("t6_arst_valid", 64'(bus.nonce_valid), 64'd0);
    check_eq("t6_arst_nonce", 64'(bus.nonce_out), 64'd0);
    check_eq("t6_arst_count", 64'(bus.count), 64'd0);
    check_eq("t6_arst_pend", 64'(bus.dbg_pending), 64'd0);
    bus.gn_match = 2'b00;
    #2;
    reset_n = 1'b1;
    cycle();
    check_eq("t6_post_rst_valid", 64'(bus.nonce_valid), 64'd0);
    check_eq("t6_post_rst_count", 64'(bus.count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
